// File: rtl/duck_sprite_fetch.sv
// Duck sprite fetch: maps the beam onto the duck box, addresses the sprite ROM, registers the colour index.
// Latency: beam sampled at edge n, rom_addr at n+1, palette_idx/duck_on at n+3.
// Backpressure: none; free-running pixel pipeline, one pixel per clock.
module duck_sprite_fetch #(
  parameter int SPR_W           = 32,
  parameter int SPR_H           = 32,
  parameter int NUM_FRAMES      = 3,
  parameter int FRAME_DIV       = 8,
  parameter int FLASH_FRAMES    = 16,
  parameter int TRANSPARENT_IDX = 1,
  parameter int ADDR_W          = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              de,
  input  logic              vsync,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic              duck_en,
  input  logic              flip,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        palette_idx,
  output logic              duck_on,
  output logic [1:0]        anim_frame
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [3:0]        TIDX        = 4'(TRANSPARENT_IDX);
  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);
  localparam logic [DW-1:0]     DIV_LAST    = DW'(FRAME_DIV - 1);
  localparam logic [1:0]        FRAME_LAST  = 2'(NUM_FRAMES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    anim_d;
  logic [DW-1:0] div_cnt, div_d;
  logic [FW-1:0] flash_cnt;
  logic          vsync_q;
  logic          frame_start;
  logic          blink;

  // beam and duck placement sampled together so S1 sees one consistent pixel
  logic [9:0]    x_s, y_s, bx_s, by_s;
  logic          de_s, en_s, flip_s;

  logic [10:0]       off_x, off_y;
  logic              in_box;
  logic [XB-1:0]     col;
  logic [ADDR_W-1:0] addr_nxt;
  logic              in_box_d1, blink_d1, in_box_d2, blink_d2;
  logic              shown;

  assign frame_start = vsync_q & ~vsync;
  assign blink       = (flash_cnt != '0) & flash_cnt[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_s    <= '0;
      y_s    <= '0;
      bx_s   <= '0;
      by_s   <= '0;
      de_s   <= 1'b0;
      en_s   <= 1'b0;
      flip_s <= 1'b0;
    end else begin
      x_s    <= DrawX;
      y_s    <= DrawY;
      bx_s   <= duck_x;
      by_s   <= duck_y;
      de_s   <= de;
      en_s   <= duck_en;
      flip_s <= flip;
    end
  end

  // 11-bit offsets: a negative offset sets the top bit, so boxes off the edge never wrap in
  assign off_x    = {1'b0, x_s} - {1'b0, bx_s};
  assign off_y    = {1'b0, y_s} - {1'b0, by_s};
  assign in_box   = de_s & en_s & (off_x[10:XB] == '0) & (off_y[10:YB] == '0);
  assign col      = flip_s ? ~off_x[XB-1:0] : off_x[XB-1:0];
  assign addr_nxt = ADDR_W'(anim_frame) * FRAME_WORDS + ADDR_W'({off_y[YB-1:0], col});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      blink_d1  <= 1'b0;
      in_box_d2 <= 1'b0;
      blink_d2  <= 1'b0;
    end else begin
      if (in_box) begin
        rom_addr <= addr_nxt;
      end
      in_box_d1 <= in_box;
      blink_d1  <= blink;
      in_box_d2 <= in_box_d1;
      blink_d2  <= blink_d1;
    end
  end

  assign shown = in_box_d2 & ~blink_d2 & (rom_q != TIDX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      palette_idx <= TIDX;
      duck_on     <= 1'b0;
    end else begin
      palette_idx <= shown ? rom_q : TIDX;
      duck_on     <= shown;
    end
  end

  // a hit outranks a coincident frame_start so the flash always gets its full length
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flash_cnt <= '0;
    end else if (hit) begin
      flash_cnt <= FW'(FLASH_FRAMES);
    end else if (frame_start && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      anim_frame <= '0;
      div_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      anim_frame <= anim_d;
      div_cnt    <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    anim_d  = anim_frame;
    div_d   = div_cnt;
    case (state_q)
      IDLE: begin
        anim_d = '0;
        div_d  = '0;
        if (duck_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!duck_en) begin
          state_d = IDLE;
          anim_d  = '0;
          div_d   = '0;
        end else if (frame_start) begin
          if (div_cnt == DIV_LAST) begin
            div_d  = '0;
            anim_d = (anim_frame == FRAME_LAST) ? 2'd0 : anim_frame + 2'd1;
          end else begin
            div_d = div_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        anim_d  = '0;
        div_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Bench for duck_sprite_fetch: sync ROM model, directed steps then random traffic vs a counting model.
module tb_duck_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, duck_x, duck_y;
  logic        de, vsync, duck_en, flip, hit;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  palette_idx;
  logic        duck_on;
  logic [1:0]  anim_frame;

  logic [3:0]  rom [0:4095];

  int compared   = 0;
  int mismatched = 0;

  // reference model: video frames counted while enabled, flash frames left, last in-box address
  int m_falls = 0;
  int m_flash = 0;
  int m_last  = 0;
  bit m_run   = 1'b0;

  duck_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .de(de), .vsync(vsync),
    .duck_x(duck_x), .duck_y(duck_y), .duck_en(duck_en), .flip(flip), .hit(hit),
    .rom_addr(rom_addr), .rom_q(rom_q), .palette_idx(palette_idx), .duck_on(duck_on),
    .anim_frame(anim_frame)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_q <= rom[rom_addr];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_anim();
    return (m_falls / 8) % 3;
  endfunction

  function automatic bit m_blink();
    return (m_flash != 0) && (((m_flash >> 1) & 1) == 1);
  endfunction

  task automatic set_en(input bit v);
    duck_en = v;
    step();
    if (!v) m_falls = 0;
    m_run = v;
  endtask

  task automatic vfall(input bit with_hit);
    vsync = 1'b0;
    hit   = with_hit;
    step();
    vsync = 1'b1;
    hit   = 1'b0;
    step();
    if (m_run) m_falls++;
    if (with_hit) m_flash = 16;
    else if (m_flash > 0) m_flash--;
    check("anim_frame", anim_frame, m_anim());
  endtask

  task automatic do_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
    m_flash = 16;
  endtask

  // one beam sample, then de=0, so only this pixel can surface exactly three edges later
  task automatic probe(input int x, input int y, input bit d);
    int ox, oy, col, addr;
    bit inb, shown;
    DrawX = 10'(x);
    DrawY = 10'(y);
    de    = d;
    step();
    de    = 1'b0;
    DrawX = '0;
    DrawY = '0;
    step();
    ox   = x - int'(duck_x);
    oy   = y - int'(duck_y);
    inb  = d && duck_en && ox >= 0 && ox < 32 && oy >= 0 && oy < 32;
    addr = m_last;
    if (inb) begin
      col    = flip ? 31 - ox : ox;
      addr   = m_anim() * 1024 + oy * 32 + col;
      m_last = addr;
    end
    check("rom_addr", rom_addr, m_last);
    step();
    check("duck_on_early", duck_on, 0);
    step();
    shown = inb && !m_blink() && (rom[addr] != 4'd1);
    check("duck_on", duck_on, shown);
    check("palette_idx", palette_idx, shown ? rom[addr] : 4'd1);
  endtask

  initial begin
    int x, y, r;
    for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom_range(0, 15));
    Reset = 1'b1; DrawX = '0; DrawY = '0; de = 1'b0; vsync = 1'b1;
    duck_x = '0; duck_y = '0; duck_en = 1'b0; flip = 1'b0; hit = 1'b0;
    step();
    step();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_palette_idx", palette_idx, 1);
    check("rst_duck_on", duck_on, 0);
    check("rst_anim_frame", anim_frame, 0);
    Reset = 1'b0;
    step();

    // basic placement, box edges, flip, transparency, de gating
    duck_x = 10'd100; duck_y = 10'd50;
    set_en(1'b1);
    rom[0] = 4'd3;
    probe(100, 50, 1'b1);
    check("first_pixel_idx", palette_idx, 3);
    probe(131, 50, 1'b1);
    probe(132, 50, 1'b1);
    probe(99, 50, 1'b1);
    flip = 1'b1;
    probe(100, 50, 1'b1);
    flip = 1'b0;
    rom[5] = 4'd1;
    probe(105, 50, 1'b1);
    probe(100, 50, 1'b0);

    // animation sequencing
    for (int i = 0; i < 16; i++) vfall(1'b0);
    probe(100, 51, 1'b1);
    check("frame2_addr", rom_addr, 2080);
    for (int i = 0; i < 8; i++) vfall(1'b0);
    for (int i = 0; i < 16; i++) vfall(1'b0);
    set_en(1'b0);
    check("en_off_anim", anim_frame, 0);
    set_en(1'b1);

    // box hanging off the right edge
    duck_x = 10'd620;
    probe(639, 60, 1'b1);
    probe(0, 61, 1'b1);

    // flash after hit, then a hit coinciding with a vsync fall
    duck_x = 10'd100;
    rom[0] = 4'd5; rom[1024] = 4'd5; rom[2048] = 4'd5;
    do_hit();
    probe(100, 50, 1'b1);
    for (int i = 0; i < 17; i++) begin
      vfall(1'b0);
      probe(100, 50, 1'b1);
    end
    do_hit();
    vfall(1'b0);
    vfall(1'b1);
    for (int i = 0; i < 3; i++) begin
      vfall(1'b0);
      probe(100, 50, 1'b1);
    end

    // reset in the middle of a visible pixel run
    for (int i = 0; i < 8; i++) vfall(1'b0);
    rom[74] = 4'd7; rom[1098] = 4'd7; rom[2122] = 4'd7;
    DrawX = 10'd110; DrawY = 10'd52; de = 1'b1;
    step(); step(); step(); step();
    #1 Reset = 1'b1;
    #1;
    check("mid_rst_rom_addr", rom_addr, 0);
    check("mid_rst_palette_idx", palette_idx, 1);
    check("mid_rst_duck_on", duck_on, 0);
    check("mid_rst_anim_frame", anim_frame, 0);
    #1 Reset = 1'b0;
    de = 1'b0;
    m_falls = 0; m_flash = 0; m_last = 0;
    probe(110, 52, 1'b1);
    m_run = 1'b1;

    // random traffic
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        duck_x = 10'($urandom_range(0, 660));
        duck_y = 10'($urandom_range(0, 490));
        flip   = 1'($urandom_range(0, 1));
        x = int'(duck_x) + int'($urandom_range(0, 40)) - 4;
        y = int'(duck_y) + int'($urandom_range(0, 40)) - 4;
        if (x < 0 || x > 639) x = int'($urandom_range(0, 639));
        if (y < 0 || y > 479) y = int'($urandom_range(0, 479));
        probe(x, y, $urandom_range(0, 9) != 0);
      end else if (r < 85) begin
        vfall($urandom_range(0, 3) == 0);
      end else if (r < 95) begin
        do_hit();
      end else begin
        set_en($urandom_range(0, 3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
